// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM access arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 1536;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select: round-robin from a pointer, or fixed lowest-index
// priority when ARB_FIXED_PRIORITY_EN is defined (pointer port then disappears).
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
`ifndef ARB_FIXED_PRIORITY_EN
  input  logic [CH_W-1:0]   ptr,
`endif
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_valid
);

  assign gnt_valid = |req;

`ifdef ARB_FIXED_PRIORITY_EN
  // Scan from the top down so the lowest requesting index is the last to write.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_idx   = CH_W'(i);
      end
    end
  end
`else
  logic [CH_W:0]   cand_wide;
  logic [CH_W-1:0] cand;

  // Walk channels in modulo order starting at ptr; first requester wins.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    cand_wide = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_wide = {1'b0, ptr} + (CH_W+1)'(i);
      if (cand_wide >= (CH_W+1)'(NUM_CH))
        cand_wide = cand_wide - (CH_W+1)'(NUM_CH);
      cand = cand_wide[CH_W-1:0];
      if (gnt_oh == '0 && req[cand]) begin
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_access_arbiter.sv
// N-channel SRAM access arbiter with req/done handshake and registered outputs.
// Build option: ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [DATA_W-1:0]        rdata,
  output logic [CH_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     read_enable,
  output logic                     write_enable,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        write_data,
  input  logic                     sram_ack,
  input  logic [DATA_W-1:0]        read_data
);

  arb_state_t        state, state_next;
  logic              take, finish;
  logic [NUM_CH-1:0] win_oh, grant_oh;
  logic [CH_W-1:0]   win_idx;
  logic              win_valid;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [CH_W-1:0]   rr_ptr;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (ch_req),
`ifndef ARB_FIXED_PRIORITY_EN
    .ptr       (rr_ptr),
`endif
    .gnt_oh    (win_oh),
    .gnt_idx   (win_idx),
    .gnt_valid (win_valid)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // take: latch a new winner; finish: SRAM acknowledged the active strobe.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (win_valid) begin
        state_next = ACCESS;
        take       = 1'b1;
      end
      ACCESS: if (sram_ack) begin
        state_next = DONE;
        finish     = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ch_done      <= '0;
      rdata        <= '0;
      grant_id     <= '0;
      grant_oh     <= '0;
      busy         <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      write_data   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr       <= '0;
`endif
    end else begin
      ch_done <= '0;
      busy    <= (state_next != IDLE);
      if (take) begin
        grant_id     <= win_idx;
        grant_oh     <= win_oh;
        read_enable  <= ~ch_write[win_idx];
        write_enable <= ch_write[win_idx];
        address      <= ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        write_data   <= ch_wdata[int'(win_idx)*DATA_W +: DATA_W];
      end
      if (finish) begin
        read_enable  <= 1'b0;
        write_enable <= 1'b0;
        ch_done      <= grant_oh;
        if (read_enable) rdata <= read_data;
      end
`ifndef ARB_FIXED_PRIORITY_EN
      if (state == DONE)
        rr_ptr <= (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + CH_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed self-checking bench for sram_access_arbiter (4 channels, default widths).
module tb_sram_access_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 1536;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     n_rst;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [DATA_W-1:0]        rdata;
  logic [CH_W-1:0]          grant_id;
  logic                     busy;
  logic                     read_enable;
  logic                     write_enable;
  logic [ADDR_W-1:0]        address;
  logic [DATA_W-1:0]        write_data;
  logic                     sram_ack;
  logic [DATA_W-1:0]        read_data;

  logic [ADDR_W-1:0] addr_tab  [NUM_CH];
  logic [DATA_W-1:0] wdata_tab [NUM_CH];
  logic [DATA_W-1:0] exp_rdata;
  int num_checks;
  int num_errors;

  sram_access_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .ch_req       (ch_req),
    .ch_write     (ch_write),
    .ch_addr      (ch_addr),
    .ch_wdata     (ch_wdata),
    .ch_done      (ch_done),
    .rdata        (rdata),
    .grant_id     (grant_id),
    .busy         (busy),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .sram_ack     (sram_ack),
    .read_data    (read_data)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_addr[g*ADDR_W +: ADDR_W]  = addr_tab[g];
    assign ch_wdata[g*DATA_W +: DATA_W] = wdata_tab[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] wr);
    ch_req   = req;
    ch_write = wr;
  endtask

  // Called on a negedge; waits for the grant, holds ack off for ack_delay cycles,
  // then completes the access and checks the done pulse and return data.
  task automatic serveChannel(input int exp_ch, input int ack_delay, input logic [DATA_W-1:0] rd_pattern);
    int   waited;
    logic is_write;
    waited = 0;
    while (!(read_enable || write_enable) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    is_write = ch_write[exp_ch];
    checkOutput("strobe_seen", 64'(read_enable | write_enable), 64'd1);
    checkOutput("grant_latency", 64'(waited), 64'd1);
    checkOutput("grant_id", 64'(grant_id), 64'(exp_ch));
    checkOutput("read_enable", 64'(read_enable), 64'(!is_write));
    checkOutput("write_enable", 64'(write_enable), 64'(is_write));
    checkOutput("address", 64'(address), 64'(addr_tab[exp_ch]));
    if (is_write) checkOutput("write_data", 64'(write_data == wdata_tab[exp_ch]), 64'd1);
    read_data = rd_pattern;
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge clk);
      checkOutput("hold_strobe", 64'({read_enable, write_enable}), 64'({!is_write, is_write}));
      checkOutput("hold_address", 64'(address), 64'(addr_tab[exp_ch]));
      checkOutput("hold_wdata", 64'(write_data == wdata_tab[exp_ch] || !is_write), 64'd1);
      checkOutput("hold_no_done", 64'(ch_done), 64'd0);
    end
    sram_ack = 1'b1;
    @(negedge clk);
    sram_ack = 1'b0;
    if (!is_write) exp_rdata = rd_pattern;
    checkOutput("ch_done", 64'(ch_done), 64'(1 << exp_ch));
    checkOutput("done_strobes", 64'({read_enable, write_enable}), 64'd0);
    checkOutput("done_busy", 64'(busy), 64'd1);
    checkOutput("rdata", 64'(rdata == exp_rdata), 64'd1);
    @(negedge clk);
    checkOutput("done_pulse_end", 64'(ch_done), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         waited;
    num_checks = 0;
    num_errors = 0;
    addr_tab[0] = 24'h000010;
    addr_tab[1] = 24'h00ABCD;
    addr_tab[2] = 24'h000100;
    addr_tab[3] = 24'h000030;
    wdata_tab[0] = {192{8'h11}};
    wdata_tab[1] = {192{8'h3C}};
    wdata_tab[2] = {192{8'h22}};
    wdata_tab[3] = {192{8'h33}};
    exp_rdata = '0;
    sram_ack  = 1'b0;
    read_data = '0;
    n_rst     = 1'b0;
    applyStimulus(4'b1111, 4'b0000);

    repeat (3) @(negedge clk);
    checkOutput("rst_strobes", 64'({read_enable, write_enable}), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(ch_done), 64'd0);
    checkOutput("rst_grant", 64'(grant_id), 64'd0);
    checkOutput("rst_address", 64'(address), 64'd0);
    checkOutput("rst_rdata", 64'(rdata == '0), 64'd1);
    n_rst = 1'b1;

`ifdef ARB_FIXED_PRIORITY_EN
    serveChannel(0, 0, {192{8'h40}});
    applyStimulus(4'b1010, 4'b0000);
    for (int t = 0; t < 3; t++) serveChannel(1, 0, {192{8'h50 + 8'(t)}});
`else
    for (int t = 0; t < 5; t++) begin
      b = 8'h40 + 8'(t);
      serveChannel(t % NUM_CH, 0, {192{b}});
    end
`endif
    applyStimulus(4'b0000, 4'b0000);

    // Stray ack with nothing in flight must not start or finish anything.
    sram_ack = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("stray_ack_busy", 64'(busy), 64'd0);
    checkOutput("stray_ack_done", 64'(ch_done), 64'd0);
    checkOutput("stray_ack_strobes", 64'({read_enable, write_enable}), 64'd0);
    sram_ack = 1'b0;

    applyStimulus(4'b0100, 4'b0000);
    serveChannel(2, 1, {192{8'hA5}});
    checkOutput("rdata_a5", 64'(rdata == {192{8'hA5}}), 64'd1);

    applyStimulus(4'b0010, 4'b0010);
    serveChannel(1, 5, {192{8'hEE}});
    checkOutput("rdata_kept_after_write", 64'(rdata == {192{8'hA5}}), 64'd1);

    applyStimulus(4'b1000, 4'b0000);
    waited = 0;
    while (!(read_enable || write_enable) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("mid_grant", 64'(grant_id), 64'd3);
    n_rst = 1'b0;
    #1;
    checkOutput("mid_rst_strobes", 64'({read_enable, write_enable}), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    applyStimulus(4'b1001, 4'b0000);
    sram_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("mid_rst_no_done", 64'(ch_done), 64'd0);
    end
    sram_ack = 1'b0;
    n_rst = 1'b1;
    exp_rdata = '0;
    serveChannel(0, 0, {192{8'h5A}});
    applyStimulus(4'b0000, 4'b0000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
